// File: rtl/chacha_stream_ctrl.sv
`timescale 1ns/1ps
// chacha_stream_ctrl: feeds one 512-bit ChaCha20 state per block into the core, returns keystream.
// Latency: first ks_valid after E0+CORE_LAT+1; CORE_LAT+2 cycles per block with ks_ready held high.
// Backpressure: ks_valid/ks_data/ks_ctr held until ks_ready; the next block is only issued after the handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, num_blocks        request (accepted in IDLE only), block count (0 = immediate done)
//   key, nonce, ctr_init     key words 0..7 / nonce words 0..2 (word0 in MSBs), first counter
//   busy, done, err          not-IDLE, one-cycle end-of-request pulse, counter-wrap abort flag
//   ks_valid/ks_ready        keystream handshake; ks_data (word0 in MSBs), ks_ctr counter used
//   core_state_in/_out       state to / result from the block core (word i at [511-32*i -: 32])
// Optional feature macro: CHACHA_CTR_WRAP_ERR_EN (abort with err when the counter would wrap mid-request).
module chacha_stream_ctrl #(
  parameter int CORE_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [255:0]     key,
  input  logic [95:0]      nonce,
  input  logic [31:0]      ctr_init,
  input  logic [CNT_W-1:0] num_blocks,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [511:0]     ks_data,
  output logic [31:0]      ks_ctr,
  output logic [511:0]     core_state_in,
  input  logic [511:0]     core_state_out
);

  localparam int WAIT_W = (CORE_LAT < 1) ? 1 : $clog2(CORE_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic [95:0]        nonce_q, nonce_d;
  logic [31:0]        ctr_q, ctr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [511:0]       cst_q, cst_d;
  logic               ks_valid_q, ks_valid_d;
  logic [511:0]       ks_data_q, ks_data_d;
  logic [31:0]        ks_ctr_q, ks_ctr_d;
  logic               done_q, done_d;
`ifdef CHACHA_CTR_WRAP_ERR_EN
  logic               err_q, err_d;
`endif

  // Constant words 0..3, then key, counter, nonce: the packing already matches word order.
  function automatic logic [511:0] build_state(input logic [255:0] k,
                                               input logic [95:0]  n,
                                               input logic [31:0]  c);
    return {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574, k, c, n};
  endfunction

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    ctr_d      = ctr_q;
    rem_d      = rem_q;
    wait_d     = wait_q;
    cst_d      = cst_q;
    ks_valid_d = ks_valid_q;
    ks_data_d  = ks_data_q;
    ks_ctr_d   = ks_ctr_q;
    done_d     = 1'b0;
`ifdef CHACHA_CTR_WRAP_ERR_EN
    err_d      = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // done_q high means we only just returned to IDLE; a start in that cycle is dropped.
        if (start && !done_q) begin
`ifdef CHACHA_CTR_WRAP_ERR_EN
          err_d = 1'b0;
`endif
          if (num_blocks == '0) begin
            done_d = 1'b1;
          end else begin
            key_d   = key;
            nonce_d = nonce;
            ctr_d   = ctr_init;
            rem_d   = num_blocks;
            cst_d   = build_state(key, nonce, ctr_init);
            wait_d  = WAIT_W'(CORE_LAT);
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        // wait_q counts the core's edges; at zero core_state_out reflects cst_q.
        if (wait_q == '0) begin
          ks_data_d  = core_state_out;
          ks_ctr_d   = ctr_q;
          ks_valid_d = 1'b1;
          state_d    = S_OUT;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      S_OUT: begin
        if (ks_valid_q && ks_ready) begin
          ks_valid_d = 1'b0;
          if (rem_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
`ifdef CHACHA_CTR_WRAP_ERR_EN
          // More blocks wanted but the counter would wrap: abort instead of reusing counter 0.
          else if (ctr_q == 32'hFFFF_FFFF) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
`endif
          else begin
            ctr_d   = ctr_q + 32'd1;
            rem_d   = rem_q - CNT_W'(1);
            cst_d   = build_state(key_q, nonce_q, ctr_q + 32'd1);
            wait_d  = WAIT_W'(CORE_LAT);
            state_d = S_RUN;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      nonce_q    <= '0;
      ctr_q      <= '0;
      rem_q      <= '0;
      wait_q     <= '0;
      cst_q      <= '0;
      ks_valid_q <= 1'b0;
      ks_data_q  <= '0;
      ks_ctr_q   <= '0;
      done_q     <= 1'b0;
`ifdef CHACHA_CTR_WRAP_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      ctr_q      <= ctr_d;
      rem_q      <= rem_d;
      wait_q     <= wait_d;
      cst_q      <= cst_d;
      ks_valid_q <= ks_valid_d;
      ks_data_q  <= ks_data_d;
      ks_ctr_q   <= ks_ctr_d;
      done_q     <= done_d;
`ifdef CHACHA_CTR_WRAP_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign ks_valid      = ks_valid_q;
  assign ks_data       = ks_data_q;
  assign ks_ctr        = ks_ctr_q;
  assign core_state_in = cst_q;
`ifdef CHACHA_CTR_WRAP_ERR_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule
